// File: rtl/mac_window_accum.sv
// mac_window_accum: sums 2**N_LOG2 accepted samples, presents sum/avg on a one-entry valid/ready register.
// Define MAC_ACC_ROUND_EN for round-half-up averaging; otherwise the average truncates.
module mac_window_accum #(
    parameter int DW     = 8,
    parameter int N_LOG2 = 3,
    parameter int AW     = DW + N_LOG2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_sum,
    output logic [DW-1:0] out_avg
);
    localparam logic [N_LOG2-1:0] CNT_LAST = '1;

    logic [AW-1:0]     r_acc;
    logic [N_LOG2-1:0] r_cnt;
    logic              r_out_valid;
    logic [AW-1:0]     r_out_sum;
    logic [DW-1:0]     r_out_avg;

    logic              w_accept;
    logic              w_emit;
    logic              w_close;
    logic [AW-1:0]     w_sum;
    logic [AW-1:0]     w_avg_src;

    assign w_sum = r_acc + AW'(in_data);

`ifdef MAC_ACC_ROUND_EN
    localparam logic [AW-1:0] HALF = AW'(1) << (N_LOG2 - 1);
    // WIN*(2^DW-1) + WIN/2 still fits in AW bits, so no carry is lost here.
    assign w_avg_src = w_sum + HALF;
`else
    assign w_avg_src = w_sum;
`endif

    // Only registered state: a close can never meet a still-pending result.
    assign in_ready = !(r_out_valid && (r_cnt == CNT_LAST));
    assign w_accept = in_valid && in_ready;
    assign w_emit   = r_out_valid && out_ready;
    assign w_close  = w_accept && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_avg   <= '0;
        end else begin
            if (w_close) begin
                r_acc       <= '0;
                r_cnt       <= '0;
                r_out_sum   <= w_sum;
                r_out_avg   <= DW'(w_avg_src >> N_LOG2);
                r_out_valid <= 1'b1;
            end else begin
                if (w_accept) begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + N_LOG2'(1);
                end
                if (w_emit) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_avg   = r_out_avg;

endmodule

// File: tb/tb_mac_window_accum.sv
// Scoreboard bench for mac_window_accum at default parameters (DW=8, N_LOG2=3).
module tb_mac_window_accum;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_sum;
    logic [7:0]  out_avg;

    mac_window_accum dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_avg   (out_avg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [10:0] sb_sum[$];
    logic [7:0]  sb_avg[$];
    logic [10:0] m_acc;
    int          m_cnt;
    logic        m_pend;

    logic        o_rdy, o_vld;
    logic [10:0] o_sum;
    logic [7:0]  o_avg;
    logic        exp_rdy, exp_vld, b_acc, b_emit, sb_empty;
    logic [10:0] exp_sum;
    logic [7:0]  exp_avg;

    function automatic logic [7:0] avg_of(input logic [10:0] s);
`ifdef MAC_ACC_ROUND_EN
        logic [11:0] t;
        t = {1'b0, s} + 12'd4;
        return t[10:3];
`else
        return s[10:3];
`endif
    endfunction

    task automatic reset_model();
        m_acc  = '0;
        m_cnt  = 0;
        m_pend = 1'b0;
        sb_sum.delete();
        sb_avg.delete();
    endtask

    // One clock of stimulus: samples outputs mid-cycle, updates the reference model, advances to next negedge.
    task automatic drive_beat(input logic v, input logic [7:0] d, input logic r);
        logic close;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
        o_rdy   = in_ready;
        o_vld   = out_valid;
        o_sum   = out_sum;
        o_avg   = out_avg;
        exp_rdy = !(m_pend && m_cnt == 7);
        exp_vld = m_pend;
        b_acc   = v && o_rdy;
        b_emit  = o_vld && r;
        sb_empty = 1'b0;
        if (b_emit) begin
            if (sb_sum.size() == 0) begin
                sb_empty = 1'b1;
            end else begin
                exp_sum = sb_sum.pop_front();
                exp_avg = sb_avg.pop_front();
            end
        end
        close = 1'b0;
        if (b_acc) begin
            m_acc = m_acc + 11'(d);
            if (m_cnt == 7) begin
                sb_sum.push_back(m_acc);
                sb_avg.push_back(avg_of(m_acc));
                m_acc = '0;
                m_cnt = 0;
                close = 1'b1;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        if (close) m_pend = 1'b1;
        else if (b_emit) m_pend = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0d exp=0", out_valid); end
        n_checks++; if (out_sum !== 11'd0) begin n_fail++; $display("FAIL reset_out_sum got=%0d exp=0", out_sum); end
        n_checks++; if (out_avg !== 8'd0) begin n_fail++; $display("FAIL reset_out_avg got=%0d exp=0", out_avg); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%0d exp=1", in_ready); end
        @(negedge clk);
        reset_model();
    endtask

    task automatic test_window(input string name, input logic [7:0] d[8], input int want_sum, input int want_avg);
        int bad_rdy = 0;
        for (int i = 0; i < 8; i++) begin
            drive_beat(1'b1, d[i], 1'b1);
            if (o_rdy !== 1'b1) bad_rdy++;
        end
        drive_beat(1'b0, 8'd0, 1'b1);
        n_checks++; if (o_vld !== 1'b1) begin n_fail++; $display("FAIL %s_valid got=%0d exp=1", name, o_vld); end
        n_checks++; if (o_sum !== 11'(want_sum)) begin n_fail++; $display("FAIL %s_sum got=%0d exp=%0d", name, o_sum, want_sum); end
        n_checks++; if (o_avg !== 8'(want_avg)) begin n_fail++; $display("FAIL %s_avg got=%0d exp=%0d", name, o_avg, want_avg); end
        n_checks++; if (sb_empty || o_sum !== exp_sum) begin n_fail++; $display("FAIL %s_scoreboard got=%0d exp=%0d", name, o_sum, exp_sum); end
        drive_beat(1'b0, 8'd0, 1'b1);
        n_checks++; if (o_vld !== 1'b0) begin n_fail++; $display("FAIL %s_pulse got=%0d exp=0", name, o_vld); end
        n_checks++; if (bad_rdy != 0) begin n_fail++; $display("FAIL %s_in_ready_low got=%0d exp=0", name, bad_rdy); end
    endtask

    task automatic test_backpressure();
        int acc_n = 0;
        for (int i = 0; i < 15; i++) begin
            drive_beat(1'b1, 8'd1, 1'b0);
            if (b_acc) acc_n++;
        end
        n_checks++; if (acc_n != 15) begin n_fail++; $display("FAIL bp_accepted got=%0d exp=15", acc_n); end
        drive_beat(1'b1, 8'd1, 1'b0);
        n_checks++; if (o_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_stall_in_ready got=%0d exp=0", o_rdy); end
        n_checks++; if (o_vld !== 1'b1 || o_sum !== 11'd8) begin n_fail++; $display("FAIL bp_first_sum got=%0d/%0d exp=1/8", o_vld, o_sum); end
        drive_beat(1'b1, 8'd1, 1'b1);
        n_checks++; if (!b_emit || b_acc || sb_empty || o_sum !== exp_sum) begin n_fail++; $display("FAIL bp_emit emit=%0d acc=%0d sum=%0d exp=1/0/%0d", b_emit, b_acc, o_sum, exp_sum); end
        drive_beat(1'b1, 8'd1, 1'b0);
        n_checks++; if (o_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_resume_in_ready got=%0d exp=1", o_rdy); end
        drive_beat(1'b0, 8'd0, 1'b0);
        n_checks++; if (o_vld !== 1'b1 || o_sum !== 11'd8) begin n_fail++; $display("FAIL bp_second_sum got=%0d/%0d exp=1/8", o_vld, o_sum); end
        drive_beat(1'b0, 8'd0, 1'b1);
        n_checks++; if (sb_empty || o_sum !== exp_sum) begin n_fail++; $display("FAIL bp_second_sb got=%0d exp=%0d", o_sum, exp_sum); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] ones[8];
        for (int i = 0; i < 5; i++) drive_beat(1'b1, 8'd50, 1'b1);
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || out_sum !== 11'd0 || out_avg !== 8'd0 || in_ready !== 1'b1)
            begin n_fail++; $display("FAIL midrst_outputs got=%0d/%0d/%0d/%0d exp=0/0/0/1", out_valid, out_sum, out_avg, in_ready); end
        reset_model();
        @(negedge clk);
        for (int i = 0; i < 8; i++) ones[i] = 8'd1;
        test_window("after_rst", ones, 8, 1);
    endtask

    task automatic test_random();
        int          n_emit = 0;
        int          cyc = 0;
        logic        prev_stall = 1'b0;
        logic [10:0] prev_sum = '0;
        logic [7:0]  prev_avg = '0;
        while (n_emit < 100 && cyc < 30000) begin
            drive_beat($urandom_range(0, 9) < 7, 8'($urandom), 1'($urandom));
            cyc++;
            n_checks++; if (o_rdy !== exp_rdy || o_vld !== exp_vld) begin n_fail++; $display("FAIL rnd_handshake cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, o_rdy, o_vld, exp_rdy, exp_vld); end
            if (prev_stall) begin
                n_checks++; if (o_vld !== 1'b1 || o_sum !== prev_sum || o_avg !== prev_avg) begin n_fail++; $display("FAIL rnd_stall_hold cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, o_sum, o_avg, prev_sum, prev_avg); end
            end
            if (b_emit) begin
                n_emit++;
                n_checks++; if (sb_empty || o_sum !== exp_sum || o_avg !== exp_avg) begin n_fail++; $display("FAIL rnd_result n=%0d got=%0d/%0d exp=%0d/%0d", n_emit, o_sum, o_avg, exp_sum, exp_avg); end
            end
            prev_stall = o_vld && !out_ready;
            prev_sum = o_sum;
            prev_avg = o_avg;
        end
        n_checks++; if (n_emit != 100) begin n_fail++; $display("FAIL rnd_window_count got=%0d exp=100", n_emit); end
        cyc = 0;
        while ((m_pend || sb_sum.size() != 0) && cyc < 20) begin
            drive_beat(1'b0, 8'd0, 1'b1);
            cyc++;
        end
        n_checks++; if (sb_sum.size() != 0 || m_pend) begin n_fail++; $display("FAIL rnd_drain got=%0d exp=0", sb_sum.size()); end
    endtask

    initial begin
        logic [7:0] d[8];
        test_reset();
        for (int i = 0; i < 8; i++) d[i] = 8'd10;
        test_window("tens", d, 80, 10);
        for (int i = 0; i < 8; i++) d[i] = 8'(i);
`ifdef MAC_ACC_ROUND_EN
        test_window("ramp", d, 28, 4);
`else
        test_window("ramp", d, 28, 3);
`endif
        for (int i = 0; i < 8; i++) d[i] = 8'd255;
        test_window("max", d, 2040, 255);
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
